// File: rtl/hilo_ctrl.sv
// HI/LO register owner: MTHI/MTLO, multi-cycle multiply and
// restoring radix-2 divide, with stall and completion handshakes.
module hilo_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LATENCY - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t      state, state_d;
    logic [4:0]  cnt;
    logic [31:0] a_q, b_q, quo, rem;
    logic        neg_q, neg_r, div_zero;
    logic        accept, is_mul, is_div, is_sgn;
    logic [32:0] trial;
    logic [63:0] sprod, uprod;

    assign is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
    assign is_div = (req_op == OP_DIV) || (req_op == OP_DIVU);
    assign is_sgn = (req_op == OP_MULT) || (req_op == OP_DIV);

    assign req_ready = (state == S_IDLE);
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready && !flush;

    // Sign-extended 64x64 product: low 64 bits equal the signed product
    assign sprod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign uprod = {32'b0, a_q} * {32'b0, b_q};
    assign trial = {rem, quo[31]} - {1'b0, b_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d = S_MUL;
                end else if (accept && is_div) begin
                    state_d = S_DIV;
                end
            end
            S_MUL: if (cnt == MUL_LAST) state_d = S_IDLE;
            S_DIV: if (cnt == DIV_LAST) state_d = S_FIX;
            S_FIX: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    logic sgn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo      <= '0;
            rem      <= '0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt      <= '0;
                a_q      <= req_a;
                sgn_q    <= is_sgn;
                rem      <= '0;
                div_zero <= (req_b == 32'd0);
                neg_q    <= is_sgn && (req_a[31] ^ req_b[31]);
                neg_r    <= is_sgn && req_a[31];
                // Divide runs on magnitudes; multiply keeps raw operands
                b_q <= (is_div && is_sgn && req_b[31]) ? -req_b : req_b;
                quo <= (is_sgn && req_a[31]) ? -req_a : req_a;
                if (req_op == OP_MTHI) begin
                    hi   <= req_a;
                    done <= 1'b1;
                end
                if (req_op == OP_MTLO) begin
                    lo   <= req_a;
                    done <= 1'b1;
                end
            end else if (!flush) begin
                unique case (state)
                    S_IDLE: ;
                    S_MUL: begin
                        cnt <= cnt + 5'd1;
                        if (cnt == MUL_LAST) begin
                            {hi, lo} <= sgn_q ? sprod : uprod;
                            done     <= 1'b1;
                        end
                    end
                    S_DIV: begin
                        cnt <= cnt + 5'd1;
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= {rem[30:0], quo[31]};
                            quo <= {quo[30:0], 1'b0};
                        end
                    end
                    S_FIX: begin
                        done <= 1'b1;
                        if (div_zero) begin
                            lo <= 32'hFFFF_FFFF;
                            hi <= a_q;
                        end else begin
                            lo <= neg_q ? -quo : quo;
                            hi <= neg_r ? -rem : rem;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer and owner of the architectural HI/LO register pair. Accepts one HI/LO-writing operation at a time from the execute stage (MTHI, MTLO, MULT, MULTU, DIV, DIVU), runs multi-cycle multiply and divide internally, and commits results to HI/LO. It also drives the stall (`req_ready`) and completion (`done`) handshakes back to the pipeline. HI/LO read paths (MFHI/MFLO) tap the `hi`/`lo` outputs directly.

## Interface
- `MUL_LATENCY`, default 2: cycles from multiply accept to HI/LO commit; legal range 1..15.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present this cycle.
- `req_ready` out 1: block idle and able to accept; high iff state is IDLE.
- `req_op` in 3: operation code.
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7 is treated as NOP.
- `req_a` in 32: rs operand; dividend, multiplicand, or MTHI/MTLO data.
- `req_b` in 32: rt operand; divisor or multiplier.
- `flush` in 1: abort the in-flight operation; has priority over everything except `reset`.
- `hi`, `lo` out 32: architectural HI/LO registers.
- `busy` out 1: multi-cycle operation in flight; equals `!req_ready`.
- `done` out 1: one-cycle pulse in the cycle after a MULT/MULTU/DIV/DIVU/MTHI/MTLO commit.

## Operation
- Accept: `req_valid && req_ready && !flush` sampled at a rising edge; operands are latched at that edge.
- States and transitions:
  - IDLE: on MUL* accept go to MUL; on DIV* accept go to DIV; on MTHI/MTLO/NOP accept stay in IDLE.
  - MUL: cycle counter reaches MUL_LATENCY-1, then commit and go to IDLE.
  - DIV: 32 iterations, then go to FIX.
  - FIX: sign correction, commit, go to IDLE.
- MTHI: `hi <= req_a` at the accepting edge; `lo` unchanged. MTLO is symmetric. No busy period.
- MULT / MULTU: 64-bit signed / unsigned product of a·b; `hi` = [63:32], `lo` = [31:0].
- DIV / DIVU: `lo` = quotient, `hi` = remainder.
  - Restoring radix-2 on magnitudes, one quotient bit per DIV cycle.
  - FIX negates the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - DIVU skips both negations.
  - Signed overflow: 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero (DIV and DIVU): `lo`=0xFFFFFFFF, `hi`=req_a unmodified, no sign fix; latency is the same as a normal divide.
- NOP accept: no state or register change, no `done`.
- `flush` in MUL/DIV/FIX: go to IDLE at that edge; no HI/LO write, no `done`.
- `flush` in IDLE: any request in that cycle is not accepted.
- Commit and a new accept cannot coincide, because `req_ready` is low in MUL/DIV/FIX.

## Timing
- Reset values: `hi`=0, `lo`=0, state IDLE, `req_ready`=1, `busy`=0, `done`=0.
  - Reset mid-operation discards the operation; HI/LO return to 0.
- Reference edge: accept at edge N.
- MTHI/MTLO: new value visible on `hi`/`lo` in cycle N+1; `done`=1 in cycle N+1; `req_ready` stays 1.
- Multiply: HI/LO written at edge N+MUL_LATENCY; `done` high in the cycle after that edge.
  - `req_ready` is low in cycles N+1 .. N+MUL_LATENCY and high again in cycle N+MUL_LATENCY+1.
- Divide:
  - DIV occupies cycles N+1..N+32; FIX occupies cycle N+33.
  - HI/LO written at edge N+33; `done` high in cycle N+34; `req_ready` high in cycle N+34.
- Back-to-back: a new request may be accepted at the first edge where `req_ready`=1, including the cycle in which `done` is high.
- `hi`/`lo` hold their old values throughout busy periods. The pipeline must stall MFHI/MFLO until `done`; this block does no forwarding.

## Test plan
- Reset, then MTHI 0x12345678 followed by MTLO 0x9ABCDEF0 on consecutive cycles: `hi`=0x12345678 and `lo`=0x9ABCDEF0; `done` pulses twice; `req_ready` never drops.
- MULT a=0xFFFFFFFF (−1), b=3 with MUL_LATENCY=2: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFD at edge N+2. The same operands with MULTU: `hi`=0x00000002, `lo`=0xFFFFFFFD.
- DIV a=−7 (0xFFFFFFF9), b=2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Commit at edge N+33, `done` in cycle N+34, `req_ready` low for exactly 33 cycles.
  - DIVU with the same operands: `lo`=0x7FFFFFFC, `hi`=1.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - DIVU 5/0 gives `lo`=0xFFFFFFFF, `hi`=5.
  - DIV −5/0 gives `lo`=0xFFFFFFFF, `hi`=0xFFFFFFFB.
- Preload HI/LO=0xAAAA/0x5555, start DIV, assert `flush` at cycle N+10: HI/LO unchanged, no `done`, `req_ready`=1 next cycle. A following MULT 6×7 gives `lo`=42, `hi`=0.
- Assert `reset` mid-multiply: all outputs return to reset values at the next edge. `flush` together with `req_valid` in IDLE: request not accepted, HI/LO unchanged.
